// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sweeps the select of an 8-to-1 channel mux, waits a
// programmable settle time on every channel, samples the mux output into a
// parallel frame register and hands each finished frame downstream over a
// valid/ready handshake.
module mux_scan_ctrl #(
  parameter int SEL_WIDTH     = 3,
  parameter int SETTLE_CYCLES = 1,
  localparam int NUM_CH       = 2 ** SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic                 mux_out,
  output logic [SEL_WIDTH-1:0] select,
  output logic                 busy,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [NUM_CH-1:0]    frame_data,
  output logic [7:0]           frame_count
);

  // Settle counter needs to hold SETTLE_CYCLES; keep at least one bit so a
  // zero settle time still yields a legal vector.
  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [SEL_WIDTH-1:0] LAST_SEL    = SEL_WIDTH'(NUM_CH - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] select_q, select_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [NUM_CH-1:0]    frame_data_q, frame_data_d;
  logic [7:0]           frame_count_q, frame_count_d;

  // Next-state logic: scan sequencing, sampling, handshake and abort.
  always_comb begin
    state_d       = state_q;
    select_d      = select_q;
    cnt_d         = cnt_q;
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    frame_count_d = frame_count_q;

    case (state_q)
      ST_IDLE: begin
        select_d = '0;
        if (start && !abort) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          frame_data_d[select_q] = mux_out;
          if (select_q != LAST_SEL) begin
            select_d = select_q + 1'b1;
            cnt_d    = SETTLE_LOAD;
          end else begin
            // Select parks on the last channel while the frame is offered.
            state_d       = ST_DONE;
            frame_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (frame_valid_q && frame_ready) begin
          frame_count_d = frame_count_q + 8'd1;
          frame_valid_d = 1'b0;
          select_d      = '0;
          if (continuous) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        select_d = '0;
      end
    endcase

    // Abort overrides everything, including a same-cycle handshake; the
    // partially filled frame and the accepted-frame count are left alone.
    if (abort && state_q != ST_IDLE) begin
      state_d       = ST_IDLE;
      select_d      = '0;
      cnt_d         = '0;
      frame_valid_d = 1'b0;
      frame_data_d  = frame_data_q;
      frame_count_d = frame_count_q;
    end
  end

  // busy is registered alongside the state it reflects.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      select_q      <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      select_q      <= select_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign select      = select_q;
  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: two instances (settle 0 and settle 2) run in
// lockstep on shared control inputs and are compared every cycle against a
// timeline model of the scan (elapsed clocks since scan start).
module tb_mux_scan_ctrl;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, continuous = 1'b0, abort = 1'b0, frame_ready = 1'b0;

  logic [2:0] sel_o   [2];
  logic       busy_o  [2];
  logic       valid_o [2];
  logic [7:0] data_o  [2];
  logic [7:0] count_o [2];
  logic       mux_o   [2];
  logic [7:0] pat     [2];

  int n_chk = 0;
  int n_err = 0;

  // Reference model: mode 0 = idle, 1 = scanning, 2 = frame offered.
  int         m_mode  [2];
  int         m_t     [2];
  logic [7:0] m_data  [2];
  int         m_cnt   [2];
  bit         begun   [2];
  int         pat_mode;
  logic [7:0] pat_fixed;
  bit         found;

  always #5 clk = ~clk;

  // Channel mux: input i carries bit i of the current pattern.
  assign mux_o[0] = pat[0][sel_o[0]];
  assign mux_o[1] = pat[1][sel_o[1]];

  mux_scan_ctrl #(.SEL_WIDTH(3), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .abort(abort), .mux_out(mux_o[0]), .select(sel_o[0]), .busy(busy_o[0]),
    .frame_valid(valid_o[0]), .frame_ready(frame_ready),
    .frame_data(data_o[0]), .frame_count(count_o[0])
  );

  mux_scan_ctrl #(.SEL_WIDTH(3), .SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .abort(abort), .mux_out(mux_o[1]), .select(sel_o[1]), .busy(busy_o[1]),
    .frame_valid(valid_o[1]), .frame_ready(frame_ready),
    .frame_data(data_o[1]), .frame_count(count_o[1])
  );

  function automatic int settle(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // Each channel lasts settle+1 clocks, so select is elapsed time / period.
  function automatic int exp_sel(input int i);
    if (m_mode[i] == 1) return m_t[i] / (settle(i) + 1);
    if (m_mode[i] == 2) return N - 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0;
      m_t[i]    = 0;
      m_data[i] = 8'h00;
      m_cnt[i]  = 0;
      begun[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    int p;
    p = settle(i) + 1;
    if (abort) begin
      m_mode[i] = 0;
    end else begin
      case (m_mode[i])
        0: if (start) begin
          m_mode[i] = 1; m_t[i] = 0; begun[i] = 1'b1;
        end
        1: begin
          m_t[i]++;
          if (m_t[i] % p == 0) m_data[i][m_t[i] / p - 1] = pat[i][m_t[i] / p - 1];
          if (m_t[i] == N * p) m_mode[i] = 2;
        end
        default: if (frame_ready) begin
          m_cnt[i] = (m_cnt[i] + 1) % 256;
          if (continuous) begin
            m_mode[i] = 1; m_t[i] = 0; begun[i] = 1'b1;
          end else begin
            m_mode[i] = 0;
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("select%0d", i), 32'(sel_o[i]), 32'(exp_sel(i)));
      chk($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(m_mode[i] != 0));
      chk($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(m_mode[i] == 2));
      chk($sformatf("data%0d", i), 32'(data_o[i]), 32'(m_data[i]));
      chk($sformatf("count%0d", i), 32'(count_o[i]), 32'(m_cnt[i]));
    end
  endtask

  function automatic logic [7:0] next_pat(input logic [7:0] cur);
    if (pat_mode == 0) return pat_fixed;
    if (pat_mode == 1) return (cur == 8'hFF) ? 8'h00 : 8'hFF;
    return 8'($urandom);
  endfunction

  // One clock: advance the model at the edge, compare just after it, then
  // pick the pattern for any frame that has just begun.
  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_all();
    for (int i = 0; i < 2; i++) begin
      if (begun[i]) begin
        pat[i]   = next_pat(pat[i]);
        begun[i] = 1'b0;
      end
    end
  endtask

  initial begin
    model_reset();
    pat[0] = 8'h00; pat[1] = 8'h00;
    pat_mode = 0; pat_fixed = 8'hA5;
    #3;
    check_all();
    #10 rst = 1'b0;
    cycle(); cycle();

    // Single frame, zero stall, pattern A5.
    start = 1'b1; frame_ready = 1'b1;
    cycle();
    start = 1'b0;
    repeat (30) cycle();
    chk("a5_data0", 32'(data_o[0]), 32'h A5);
    chk("a5_data1", 32'(data_o[1]), 32'h A5);
    chk("a5_count0", 32'(count_o[0]), 32'd1);

    // Backpressure: frame must hold while ready is low.
    pat_fixed = 8'h3C; frame_ready = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (40) cycle();
    chk("stall_data1", 32'(data_o[1]), 32'h3C);
    chk("stall_sel1", 32'(sel_o[1]), 32'd7);
    frame_ready = 1'b1;
    repeat (5) cycle();
    chk("stall_count1", 32'(count_o[1]), 32'd2);

    // Continuous back-to-back frames with toggling pattern.
    pat_mode = 1; continuous = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (80) cycle();
    continuous = 1'b0;
    repeat (30) cycle();

    // Abort at channel 4 of the slow instance; start pulses mid-scan ignored.
    pat_mode = 2; frame_ready = 1'b0; start = 1'b1;
    cycle();
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (m_mode[1] == 1 && exp_sel(1) == 4) found = 1'b1;
      else begin
        start = (k % 3 == 0);
        cycle();
      end
    end
    chk("abort_reach", 32'(found), 32'd1);
    start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    chk("abort_sel1", 32'(sel_o[1]), 32'd0);
    repeat (10) cycle();
    frame_ready = 1'b1;
    repeat (5) cycle();

    // Random traffic.
    repeat (1500) begin
      start       = ($urandom % 4 == 0);
      continuous  = ($urandom % 2 == 0);
      abort       = ($urandom % 30 == 0);
      frame_ready = ($urandom % 3 != 0);
      cycle();
    end

    // Long continuous run: both frame counters wrap past 255.
    abort = 1'b0; start = 1'b1; continuous = 1'b1; frame_ready = 1'b1;
    repeat (260 * 25 + 30) cycle();

    // Asynchronous reset between edges while the slow instance is on channel 5.
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (m_mode[1] == 1 && exp_sel(1) == 5) found = 1'b1;
      else cycle();
    end
    chk("rst_reach", 32'(found), 32'd1);
    start = 1'b0; continuous = 1'b0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #3 rst = 1'b0;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (30) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequential scanner that drives the 3-bit select of the 8-to-1 channel multiplexer. It sweeps channels 0..NUM_CH-1, waits a programmable settle time per channel, and samples the mux output into a parallel frame register. It presents each completed frame on a valid/ready handshake to the downstream consumer. It sits directly upstream of the mux (owns `select`) and consumes the mux `out`.

Parameters:
- SEL_WIDTH, 3, width of mux select; NUM_CH = 2**SEL_WIDTH channels per frame.
- SETTLE_CYCLES, 1, idle clocks per channel between select change and sample; 0 is legal.

Ports:
- clk  input  1  single clock; all state rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- continuous  input  1  1 = after handshake, immediately rescan; sampled in DONE at handshake.
- abort  input  1  synchronous; discard partial frame, return to IDLE.
- mux_out  input  1  output of the channel mux.
- select  output  SEL_WIDTH  channel select driven to the mux.
- busy  output  1  high in SETTLE or DONE.
- frame_valid  output  1  frame_data holds a complete frame.
- frame_ready  input  1  downstream accepts frame.
- frame_data  output  NUM_CH  bit i = sample of channel i.
- frame_count  output  8  completed-and-accepted frames, wraps 255->0.

Behaviour:
- Reset (async, rst=1): state=IDLE; select=0, busy=0, frame_valid=0, frame_data=0, frame_count=0, settle counter=0. Release is synchronous to clk.
- Settle counter width: clog2(SETTLE_CYCLES+1), minimum 1 bit.
- IDLE:
  - select=0.
  - start=1 at edge E0 -> SETTLE, select=0, cnt<=SETTLE_CYCLES.
- SETTLE:
  - Each edge: if cnt!=0 then cnt<=cnt-1. Else frame_data[select]<=mux_out (sample).
  - After a sample, if select!=NUM_CH-1: select<=select+1, cnt<=SETTLE_CYCLES.
  - After sampling the last channel: -> DONE, frame_valid<=1, select holds NUM_CH-1.
  - Each channel occupies SETTLE_CYCLES+1 clocks. frame_valid is high after edge E0+NUM_CH*(SETTLE_CYCLES+1).
- DONE:
  - frame_valid=1; frame_data stable; scan stalls (backpressure, no samples lost or overwritten).
  - frame_valid & frame_ready at an edge: frame_count<=frame_count+1 (mod 256) and frame_valid<=0.
  - If continuous=1 at that edge: -> SETTLE, select<=0, cnt<=SETTLE_CYCLES. Else -> IDLE.
- frame_data is written bit-by-bit during a scan. Consumers use it only while frame_valid=1. Bits from the previous frame persist until overwritten.
- start is ignored outside IDLE. start and abort together in IDLE: abort wins (stay IDLE).
- abort=1 in SETTLE or DONE: next state IDLE, select<=0, frame_valid<=0, frame_count unchanged, frame_data unchanged. abort has priority over frame_ready in the same cycle (no count increment).
- rst asserted mid-scan: immediate return to reset values regardless of clk.
- busy = (state != IDLE), registered with state.

Test Plan:
- SETTLE_CYCLES=0, mux model returns in_i = pattern 8'hA5 bit i, start pulse at E0, frame_ready=1 -> select steps 0..7 on consecutive edges; frame_valid high after E8; frame_data=8'hA5; frame_count=1; back to IDLE.
- SETTLE_CYCLES=2, pattern 8'h3C, frame_ready=0 for 10 cycles after valid -> each select value held 3 clocks; frame_valid high after E24; frame_data stays 8'h3C and select stays 7 while stalled; count increments exactly once on ready.
- continuous=1, frame_ready=1, pattern toggles 8'hFF/8'h00 per frame -> back-to-back frames with no IDLE gap, select returns to 0 the cycle after handshake, frame_count reaches 3 after 3 frames.
- Preload frame_count to 255 via 255 frames, then one more -> frame_count wraps to 0.
- abort at select=4 during SETTLE -> IDLE next cycle, select=0, frame_valid never asserts, frame_count unchanged. Assert start during the scan -> ignored.
- rst asserted between clock edges at select=5 -> all outputs 0 immediately. After release, start -> clean scan from channel 0.
